// File: rtl/cu_pkg.sv
// Shared definitions for the 8-bit computer control unit: opcodes,
// microstep numbers and the layout of the 16-bit control word.
package cu_pkg;

    localparam int CW_W = 16;

    // Control-word bit positions
    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    typedef enum logic [1:0] {
        CS_FETCH  = 2'd0,
        CS_EXEC   = 2'd1,
        CS_HALTED = 2'd2
    } cu_state_e;

endpackage

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and a flag
// marking the final step of the current instruction.
// Build option CU_EARLY_END_EN: when defined, last_step marks the last active
// step of each opcode; otherwise only T4 ends an instruction.
module microcode_rom
    import cu_pkg::*;
(
    input  logic [3:0]      opcode,
    input  logic [2:0]      step,
    input  logic            fz,
    input  logic            fc,
    output logic [CW_W-1:0] ctrl_word,
    output logic            last_step
);

    // Control word decode; fetch steps are opcode independent
    always_comb begin
        ctrl_word = '0;
        case (step)
            T0: begin
                ctrl_word[CW_CO] = 1'b1;
                ctrl_word[CW_MI] = 1'b1;
            end
            T1: begin
                ctrl_word[CW_RO] = 1'b1;
                ctrl_word[CW_II] = 1'b1;
                ctrl_word[CW_CE] = 1'b1;
            end
            default: begin
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                        if (step == T2) begin
                            ctrl_word[CW_IO] = 1'b1;
                            ctrl_word[CW_MI] = 1'b1;
                        end else if (step == T3) begin
                            if (opcode == OP_STA) begin
                                ctrl_word[CW_AO] = 1'b1;
                                ctrl_word[CW_RI] = 1'b1;
                            end else begin
                                ctrl_word[CW_RO] = 1'b1;
                                ctrl_word[CW_AI] = (opcode == OP_LDA);
                                ctrl_word[CW_BI] = (opcode != OP_LDA);
                            end
                        end else if (step == T4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
                            ctrl_word[CW_EO] = 1'b1;
                            ctrl_word[CW_AI] = 1'b1;
                            ctrl_word[CW_FI] = 1'b1;
                            ctrl_word[CW_SU] = (opcode == OP_SUB);
                        end
                    end
                    OP_LDI: begin
                        ctrl_word[CW_IO] = (step == T2);
                        ctrl_word[CW_AI] = (step == T2);
                    end
                    OP_JMP, OP_JC, OP_JZ: begin
                        if (step == T2 && (opcode == OP_JMP ||
                                           (opcode == OP_JC && fc) ||
                                           (opcode == OP_JZ && fz))) begin
                            ctrl_word[CW_IO] = 1'b1;
                            ctrl_word[CW_J]  = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        ctrl_word[CW_AO] = (step == T2);
                        ctrl_word[CW_OI] = (step == T2);
                    end
                    OP_HLT: begin
                        ctrl_word[CW_HLT] = (step == T2);
                    end
                    default: ;
                endcase
            end
        endcase
    end

`ifdef CU_EARLY_END_EN
    logic [2:0] end_step;

    // Last active step per opcode; conditional jumps end at T2 either way
    always_comb begin
        end_step = T1;
        case (opcode)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: end_step = T2;
            OP_LDA, OP_STA:                               end_step = T3;
            OP_ADD, OP_SUB:                               end_step = T4;
            default:                                      end_step = T1;
        endcase
        last_step = (step == end_step);
    end
`else
    // Every instruction occupies the full T0..T4 window
    always_comb begin
        last_step = (step == T4);
    end
`endif

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer: step counter, halt latch and reset gating around the
// microcode ROM. Build option CU_EARLY_END_EN shortens instructions to their
// last active step (handled inside microcode_rom).
//
// state     | meaning
// ----------+------------------------------------------------
// CS_FETCH  | T0..T1, fetching the instruction
// CS_EXEC   | T2..T4, executing the opcode
// CS_HALTED | HLT executed; STEP frozen at 2, only rst leaves
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] OPCODE,
    input  logic       FZ,
    input  logic       FC,
    output logic       HLT,
    output logic       MI,
    output logic       RI,
    output logic       RO,
    output logic       II,
    output logic       IO,
    output logic       AI,
    output logic       AO,
    output logic       BI,
    output logic       EO,
    output logic       SU,
    output logic       FI,
    output logic       OI,
    output logic       CE,
    output logic       CO,
    output logic       J,
    output logic [2:0] STEP
);

    cu_state_e       state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [CW_W-1:0] rom_word;
    logic            rom_last;
    logic [CW_W-1:0] ctrl;

    microcode_rom u_rom (
        .opcode    (OPCODE),
        .step      (step_q),
        .fz        (FZ),
        .fc        (FC),
        .ctrl_word (rom_word),
        .last_step (rom_last)
    );

    // Next step / state: halt at HLT's T2, wrap after the last step
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            CS_HALTED: ;
            default: begin
                if (rom_word[CW_HLT]) begin
                    state_d = CS_HALTED;
                end else if (rom_last) begin
                    step_d  = T0;
                    state_d = CS_FETCH;
                end else begin
                    step_d  = 3'(step_q + 3'd1);
                    state_d = (step_d >= T2) ? CS_EXEC : CS_FETCH;
                end
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CS_FETCH;
            step_q  <= T0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Output gating: quiet during reset, only HLT while halted
    always_comb begin
        ctrl = '0;
        STEP = T0;
        if (!rst) begin
            STEP = step_q;
            if (state_q == CS_HALTED) begin
                ctrl[CW_HLT] = 1'b1;
            end else begin
                ctrl = rom_word;
            end
        end
    end

    assign HLT = ctrl[CW_HLT];
    assign MI  = ctrl[CW_MI];
    assign RI  = ctrl[CW_RI];
    assign RO  = ctrl[CW_RO];
    assign II  = ctrl[CW_II];
    assign IO  = ctrl[CW_IO];
    assign AI  = ctrl[CW_AI];
    assign AO  = ctrl[CW_AO];
    assign BI  = ctrl[CW_BI];
    assign EO  = ctrl[CW_EO];
    assign SU  = ctrl[CW_SU];
    assign FI  = ctrl[CW_FI];
    assign OI  = ctrl[CW_OI];
    assign CE  = ctrl[CW_CE];
    assign CO  = ctrl[CW_CO];
    assign J   = ctrl[CW_J];

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level reference model
// pushes the expected (STEP, control signals) for every cycle; a monitor on
// the falling edge pops and compares against the DUT outputs.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] OPCODE;
    logic       FZ, FC;
    logic       HLT, MI, RI, RO, II, IO, AI, AO, BI, EO, SU, FI, OI, CE, CO, J;
    logic [2:0] STEP;

    control_unit dut (
        .clk(clk), .rst(rst), .OPCODE(OPCODE), .FZ(FZ), .FC(FC),
        .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .II(II), .IO(IO),
        .AI(AI), .AO(AO), .BI(BI), .EO(EO), .SU(SU), .FI(FI),
        .OI(OI), .CE(CE), .CO(CO), .J(J), .STEP(STEP)
    );

    // Bench-local signal masks
    localparam logic [15:0] M_HLT = 16'h0001, M_MI = 16'h0002, M_RI = 16'h0004, M_RO = 16'h0008;
    localparam logic [15:0] M_II  = 16'h0010, M_IO = 16'h0020, M_AI = 16'h0040, M_AO = 16'h0080;
    localparam logic [15:0] M_BI  = 16'h0100, M_EO = 16'h0200, M_SU = 16'h0400, M_FI = 16'h0800;
    localparam logic [15:0] M_OI  = 16'h1000, M_CE = 16'h2000, M_CO = 16'h4000, M_J  = 16'h8000;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] sig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signals the instruction should assert in microstep t
    function automatic logic [15:0] model_sig(input logic [3:0] op, input int t,
                                              input logic fz, input logic fc);
        if (t == 0) return M_CO | M_MI;
        if (t == 1) return M_RO | M_II | M_CE;
        case (op)
            4'h1: return (t == 2) ? (M_IO | M_MI) : (t == 3) ? (M_RO | M_AI) : 16'h0;
            4'h2: return (t == 2) ? (M_IO | M_MI) : (t == 3) ? (M_RO | M_BI) : (M_EO | M_AI | M_FI);
            4'h3: return (t == 2) ? (M_IO | M_MI) : (t == 3) ? (M_RO | M_BI) : (M_EO | M_AI | M_FI | M_SU);
            4'h4: return (t == 2) ? (M_IO | M_MI) : (t == 3) ? (M_AO | M_RI) : 16'h0;
            4'h5: return (t == 2) ? (M_IO | M_AI) : 16'h0;
            4'h6: return (t == 2) ? (M_IO | M_J) : 16'h0;
            4'h7: return (t == 2 && fc) ? (M_IO | M_J) : 16'h0;
            4'h8: return (t == 2 && fz) ? (M_IO | M_J) : 16'h0;
            4'hE: return (t == 2) ? (M_AO | M_OI) : 16'h0;
            4'hF: return (t == 2) ? M_HLT : 16'h0;
            default: return 16'h0;
        endcase
    endfunction

    // Number of cycles an instruction occupies (HLT handled separately)
    function automatic int instr_len(input logic [3:0] op);
`ifdef CU_EARLY_END_EN
        case (op)
            4'h1, 4'h4:                   return 4;
            4'h2, 4'h3:                   return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE: return 3;
            default:                      return 2;
        endcase
`else
        return (op == 4'hF) ? 3 : 5;
`endif
    endfunction

    // Flag source: 0/1 forced, 2 random each cycle
    function automatic logic flag_val(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            rst    = 1'b1;
            OPCODE = 4'($urandom_range(0, 15));
            FZ     = 1'($urandom_range(0, 1));
            FC     = 1'($urandom_range(0, 1));
            exp_q.push_back('{step: 3'd0, sig: 16'h0});
        end
    endtask

    // Run one instruction, optionally cut short after `limit` cycles
    task automatic run_instr(input logic [3:0] op, input int fzm, input int fcm, input int limit);
        int n;
        n = (op == 4'hF) ? 3 : instr_len(op);
        if (limit < n) n = limit;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            rst    = 1'b0;
            OPCODE = op;
            FZ     = flag_val(fzm);
            FC     = flag_val(fcm);
            exp_q.push_back('{step: 3'(t), sig: model_sig(op, t, FZ, FC)});
        end
        if (op == 4'hF && n == 3) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                FZ = 1'($urandom_range(0, 1));
                FC = 1'($urandom_range(0, 1));
                exp_q.push_back('{step: 3'd2, sig: M_HLT});
            end
        end
    endtask

    // Monitor: compare every cycle that has an expectation queued
    initial begin
        exp_t e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {J, CO, CE, OI, FI, SU, EO, BI, AO, AI, IO, II, RO, RI, MI, HLT};
                checks++;
                if (act !== e.sig || STEP !== e.step) begin
                    failures++;
                    $display("FAIL ctrl cyc=%0d op=%h: got step=%0d sig=%h, expected step=%0d sig=%h",
                             cyc, OPCODE, STEP, act, e.step, e.sig);
                end
            end
        end
    end

    initial begin
        logic [3:0] op;
        rst = 1'b1; OPCODE = 4'h0; FZ = 1'b0; FC = 1'b0;

        do_reset(2);
        run_instr(4'h0, 2, 2, 99);      // NOP
        run_instr(4'hB, 2, 2, 99);      // undefined behaves as NOP
        run_instr(4'h2, 2, 2, 99);      // ADD
        run_instr(4'h3, 2, 2, 99);      // SUB
        run_instr(4'h7, 2, 1, 99);      // JC taken
        run_instr(4'h7, 2, 0, 99);      // JC not taken
        run_instr(4'h8, 1, 2, 99);      // JZ taken
        run_instr(4'h8, 0, 2, 99);      // JZ not taken
        run_instr(4'h1, 2, 2, 99);
        run_instr(4'h4, 2, 2, 99);
        run_instr(4'h5, 2, 2, 99);
        run_instr(4'h6, 2, 2, 99);
        run_instr(4'hE, 2, 2, 99);
        run_instr(4'h1, 2, 2, 3);       // LDA cut off at T3 by reset
        do_reset(1);
        run_instr(4'h0, 2, 2, 99);
        run_instr(4'hF, 2, 2, 99);      // HLT then 20 halted cycles
        do_reset(1);
        run_instr(4'h2, 2, 2, 99);

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 19) == 0) begin
                run_instr(op, 2, 2, $urandom_range(1, 4));
                do_reset($urandom_range(1, 2));
            end else begin
                run_instr(op, 2, 2, 99);
            end
        end

        run_instr(4'hF, 2, 2, 99);
        do_reset(2);
        run_instr(4'h0, 2, 2, 99);

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded sequencer for the 8-bit computer. It steps through fetch and execute microsteps and decodes the 4-bit opcode from the instruction register into the per-cycle control word that drives every bus stage. It sits directly downstream of the flag register: it consumes `FZ`/`FC` for conditional jumps and issues the `FI` that tells the flag register to capture the ALU's carry and zero outputs.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `OPCODE`  in  4  upper nibble of the instruction register.
- `FZ`, `FC`  in  1 each  zero and carry flags from the flag register.
- `HLT`  out  1  clock halt; held high once the machine is halted.
- `MI`, `RI`, `RO`  out  1 each  MAR in; RAM in; RAM out.
- `II`, `IO`  out  1 each  instruction register in; operand (low nibble) out.
- `AI`, `AO`, `BI`  out  1 each  A register in/out; B register in.
- `EO`, `SU`, `FI`  out  1 each  ALU out; subtract; flag register in.
- `OI`, `CE`, `CO`, `J`  out  1 each  output register in; PC enable; PC out; jump (PC load).
- `STEP`  out  3  current microstep, 0–4, for debug and display.

## Operation
- Microstep counter `STEP` runs T0..T4. T0: `CO MI`. T1: `RO II CE`. T2–T4 depend on `OPCODE`:
  - NOP 0x0: no signals.
  - LDA 0x1: T2 `IO MI`; T3 `RO AI`.
  - ADD 0x2: T2 `IO MI`; T3 `RO BI`; T4 `EO AI FI`.
  - SUB 0x3: same as ADD, plus `SU` in T4.
  - STA 0x4: T2 `IO MI`; T3 `AO RI`.
  - LDI 0x5: T2 `IO AI`.
  - JMP 0x6: T2 `IO J`.
  - JC 0x7: T2 `IO J` if `FC`=1, otherwise nothing.
  - JZ 0x8: T2 `IO J` if `FZ`=1, otherwise nothing.
  - OUT 0xE: T2 `AO OI`.
  - HLT 0xF: T2 `HLT`.
  - Undefined opcodes (0x9–0xD) execute as NOP.
- Control state: FETCH (T0–T1), EXEC (T2–T4), HALTED.
  - T4 wraps to T0.
  - In HALTED, `STEP` freezes at 2, `HLT`=1, and all other outputs are 0. Only `rst` leaves HALTED.
- Flags are sampled combinationally in T2. Flags written by `FI` in an ADD/SUB T4 are therefore visible to the next instruction's T2.
- Reset: while `rst`=1, all control outputs are forced to 0. At the next edge, `STEP`=0 and HALTED is cleared. In the first cycle after reset, `CO`=`MI`=1. Reset mid-instruction or during HALTED behaves identically.

## Timing
- Control outputs are combinational from registered state (`STEP`, halted), `OPCODE`, and flags. They are valid for the whole cycle and act at the next rising edge.
- The step register is the only latency: one step per clock.
- A full instruction takes 5 cycles, or fewer with `CU_EARLY_END_EN`.
- Halting: `HLT` is asserted in T2 of HLT. The halted state is registered at the end of that cycle, and `HLT` stays high from then on.
- `OPCODE` must be stable from T2 onward. The IR captures it at the end of T1.

## Configuration
- `CU_EARLY_END_EN` defined: after the last active step of the instruction, the counter returns to T0.
  - Last active step: NOP and undefined after T1; LDI, JMP, JC, JZ, OUT after T2; LDA, STA after T3; ADD, SUB after T4.
  - JC/JZ end after T2 whether or not the jump is taken.
- Not defined: every instruction takes T0–T4 and idle steps issue no signals.
- The control word for any active step is identical in both builds.

## Structure
- Shared package or include `cu_pkg`:
  - opcode constants (`OP_NOP` … `OP_HLT`);
  - step constants `T0`–`T4`;
  - control-word bit indices and the width constant (16).
- One natural sub-module: `microcode_rom`, combinational (`OPCODE`, `STEP`, `FZ`, `FC`) → 16-bit control word plus a `last_step` bit. `control_unit` holds the step counter, halted state, and reset gating.

## Test plan
- Reset then run NOP: `rst` for 2 cycles, `OPCODE`=0x0.
  - Expect `CO MI` at T0, `RO II CE` at T1, then idle.
  - `STEP` sequence 0,1,2,3,4,0 without the macro; 0,1,0 with it.
- ADD (0x2): expect T2 `IO MI`, T3 `RO BI`, T4 `EO AI FI` with `SU`=0. SUB (0x3) is identical except `SU`=1 in T4.
- JC (0x7):
  - With `FC`=1, `IO J`=1 at T2.
  - With `FC`=0, `J`=0 throughout.
  - JZ (0x8) is checked the same way against `FZ`.
- HLT (0xF): `HLT` rises at T2 and `STEP` holds at 2 for 20 cycles with all other outputs 0. `rst` then gives `STEP`=0 and `CO MI` on the next cycle.
- Reset mid-instruction: assert `rst` at T3 of LDA.
  - All outputs are 0 during reset.
  - The next cycle is T0 with `CO MI`.
- Undefined opcode 0xB behaves exactly as NOP in both builds.
